ext_bus_master: RTL and testbench

- Chip-side initiator for the external multiplexed 16-bit memory bus: two transparent address latches (le_lo/le_hi), read enable OEb, byte-lane write strobes WEb_lo/WEb_hi.
- Turns 32-bit internal requests (valid/ready) into two halfword bus cycles.
- Sits between the core's memory port and the mprj_io pads [26:5].
- External address is halfword-granular: ext_addr = {1'b0, req_addr[31:2], hw}, with hw = 0 for the low halfword and 1 for the high halfword.

---
 rtl/ext_bus_pkg.sv | 35 +++
 rtl/ext_bus_master.sv | 225 ++++++++++++++++++++++
 tb/tb_ext_bus_master.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ext_bus_pkg.sv
// Shared definitions for the external multiplexed 16-bit bus initiator:
// FSM state encoding, idle levels of the pad-side controls, and the
// halfword-granular external address helper.
package ext_bus_pkg;

    localparam int EXT_AW = 32;
    localparam int WCNT_W = 4;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_LHI    = 4'd1,
        ST_LHI_H  = 4'd2,
        ST_LLO    = 4'd3,
        ST_LLO_H  = 4'd4,
        ST_RD     = 4'd5,
        ST_RD_END = 4'd6,
        ST_WR     = 4'd7,
        ST_WR_END = 4'd8
    } state_e;

    // Levels of the bus controls whenever no phase is driving them
    localparam logic        IDLE_LE     = 1'b0;
    localparam logic        IDLE_OEB    = 1'b1;
    localparam logic        IDLE_WEB    = 1'b1;
    localparam logic        IDLE_DIR    = 1'b0;
    localparam logic        IDLE_BUS_OE = 1'b0;
    localparam logic [15:0] IDLE_BUS    = 16'h0000;

    // External halfword address: bit 31 is always 0, bit 0 selects the halfword
    function automatic logic [EXT_AW-1:0] ext_addr(input logic [29:0] word_addr,
                                                   input logic        hw);
        return {1'b0, word_addr, hw};
    endfunction

endpackage

// File: rtl/ext_bus_master.sv
// Chip-side initiator for the external multiplexed 16-bit memory bus.
// Each 32-bit request becomes up to two halfword cycles (low halfword first),
// preceded by an upper-address latch phase unless the upper bits are cached.
module ext_bus_master
    import ext_bus_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 0,
    parameter bit          HI_CACHE    = 1'b1
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [15:0] bus_out,
    input  logic [15:0] bus_in,
    output logic        bus_oe,
    output logic        le_lo,
    output logic        le_hi,
    output logic        bus_dir,
    output logic        OEb,
    output logic        WEb_lo,
    output logic        WEb_hi
);

    localparam logic [WCNT_W-1:0] W_LOAD = WCNT_W'(WAIT_CYCLES);

    state_e              r_state;
    state_e              w_state_nxt;
    logic [29:0]         r_waddr;
    logic                r_we;
    logic [31:0]         r_wdata;
    logic [3:0]          r_wstrb;
    logic                r_hw;
    logic [31:0]         r_rdata;
    logic [WCNT_W-1:0]   r_wcnt;
    logic                r_hi_valid;
    logic [15:0]         r_hi_tag;
    logic                r_resp_valid;
    logic                r_init_done;

    logic                w_accept;
    logic                w_done;
    logic                w_hi_hit;
    logic                w_more;
    logic [1:0]          w_hw_strb;
    logic [15:0]         w_hw_data;
    logic [EXT_AW-1:0]   w_cur_ext;
    logic [EXT_AW-1:0]   w_req_ext;
    logic                w_unused;

    assign w_accept  = req_valid & req_ready;
    assign w_cur_ext = ext_addr(r_waddr, r_hw);
    assign w_req_ext = ext_addr(req_addr[31:2], 1'b0);
    assign w_hi_hit  = (HI_CACHE == 1'b1) && r_hi_valid && (r_hi_tag == w_req_ext[31:16]);
    assign w_hw_strb = r_hw ? r_wstrb[3:2] : r_wstrb[1:0];
    assign w_hw_data = r_hw ? r_wdata[31:16] : r_wdata[15:0];
    // Another halfword follows only after halfword 0, and for writes only if it has strobes
    assign w_more    = (r_hw == 1'b0) && ((r_we == 1'b0) || (r_wstrb[3:2] != 2'b00));
    assign w_unused  = ^{req_addr[1:0], w_req_ext[15:0]};

    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_rdata;

    // State register
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state sequencing and completion detection
    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (req_we && (req_wstrb == 4'b0000)) begin
                        w_state_nxt = ST_IDLE;
                        w_done      = 1'b1;
                    end else if (w_hi_hit) begin
                        w_state_nxt = ST_LLO;
                    end else begin
                        w_state_nxt = ST_LHI;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_LHI:   w_state_nxt = ST_LHI_H;
            ST_LHI_H: w_state_nxt = ST_LLO;
            ST_LLO:   w_state_nxt = ST_LLO_H;
            ST_LLO_H: w_state_nxt = r_we ? ST_WR : ST_RD;
            ST_RD: begin
                if (r_wcnt == '0) begin
                    w_state_nxt = ST_RD_END;
                end else begin
                    w_state_nxt = ST_RD;
                end
            end
            ST_WR: begin
                if (r_wcnt == '0) begin
                    w_state_nxt = ST_WR_END;
                end else begin
                    w_state_nxt = ST_WR;
                end
            end
            ST_RD_END, ST_WR_END: begin
                if (w_more) begin
                    w_state_nxt = ST_LLO;
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_done      = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Request capture, wait counter, read data assembly and upper-address cache
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_waddr      <= 30'd0;
            r_we         <= 1'b0;
            r_wdata      <= 32'd0;
            r_wstrb      <= 4'd0;
            r_hw         <= 1'b0;
            r_rdata      <= 32'd0;
            r_wcnt       <= '0;
            r_hi_valid   <= 1'b0;
            r_hi_tag     <= 16'd0;
            r_resp_valid <= 1'b0;
            r_init_done  <= 1'b0;
        end else begin
            r_init_done  <= 1'b1;
            r_resp_valid <= w_done;
            if (w_accept) begin
                r_waddr <= req_addr[31:2];
                r_we    <= req_we;
                r_wdata <= req_wdata;
                r_wstrb <= req_wstrb;
                // A write with no low-halfword strobes starts directly on halfword 1
                r_hw    <= req_we & (req_wstrb[1:0] == 2'b00);
            end
            if (r_state == ST_LHI_H) begin
                r_hi_tag   <= w_cur_ext[31:16];
                r_hi_valid <= 1'b1;
            end
            if (r_state == ST_LLO_H) begin
                r_wcnt <= W_LOAD;
            end else if (((r_state == ST_RD) || (r_state == ST_WR)) && (r_wcnt != '0)) begin
                r_wcnt <= r_wcnt - WCNT_W'(1);
            end
            if ((r_state == ST_RD) && (r_wcnt == '0)) begin
                if (r_hw) begin
                    r_rdata[31:16] <= bus_in;
                end else begin
                    r_rdata[15:0]  <= bus_in;
                end
            end
            if (((r_state == ST_RD_END) || (r_state == ST_WR_END)) && w_more) begin
                r_hw <= 1'b1;
            end
        end
    end

    // Moore decode of the pad-side controls from the current phase
    always_comb begin
        req_ready = 1'b0;
        bus_out   = IDLE_BUS;
        bus_oe    = IDLE_BUS_OE;
        le_lo     = IDLE_LE;
        le_hi     = IDLE_LE;
        bus_dir   = IDLE_DIR;
        OEb       = IDLE_OEB;
        WEb_lo    = IDLE_WEB;
        WEb_hi    = IDLE_WEB;
        case (r_state)
            ST_IDLE: req_ready = r_init_done;
            ST_LHI: begin
                le_hi   = 1'b1;
                bus_out = w_cur_ext[31:16];
                bus_oe  = 1'b1;
            end
            ST_LHI_H: begin
                bus_out = w_cur_ext[31:16];
                bus_oe  = 1'b1;
            end
            ST_LLO: begin
                le_lo   = 1'b1;
                bus_out = w_cur_ext[15:0];
                bus_oe  = 1'b1;
            end
            ST_LLO_H: begin
                bus_out = w_cur_ext[15:0];
                bus_oe  = 1'b1;
            end
            ST_RD: begin
                bus_dir = 1'b1;
                OEb     = 1'b0;
            end
            ST_RD_END: bus_dir = 1'b1;
            ST_WR: begin
                bus_out = w_hw_data;
                bus_oe  = 1'b1;
                WEb_lo  = ~w_hw_strb[0];
                WEb_hi  = ~w_hw_strb[1];
            end
            ST_WR_END: begin
                bus_out = w_hw_data;
                bus_oe  = 1'b1;
            end
            default: req_ready = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_ext_bus_master.sv
// Bench for ext_bus_master: two instances (WAIT_CYCLES 0 and 2), each attached
// to a modelled external device (transparent latches + halfword memory).
// Expectations come from a request-level reference model.
module tb_ext_bus_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        rst_q = 1'b0;
    logic        req_valid_a [2];
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        req_ready_a [2];
    logic        resp_valid_a [2];
    logic [31:0] resp_rdata_a [2];
    logic [15:0] bus_out_a [2];
    logic [15:0] bus_in_a [2];
    logic        bus_oe_a [2];
    logic        le_lo_a [2];
    logic        le_hi_a [2];
    logic        bus_dir_a [2];
    logic        oeb_a [2];
    logic        web_lo_a [2];
    logic        web_hi_a [2];

    ext_bus_master #(.WAIT_CYCLES(0), .HI_CACHE(1'b1)) u_dut0 (
        .wb_clk_i(clk), .wb_rst_i(rst), .req_valid(req_valid_a[0]), .req_ready(req_ready_a[0]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid_a[0]), .resp_rdata(resp_rdata_a[0]), .bus_out(bus_out_a[0]),
        .bus_in(bus_in_a[0]), .bus_oe(bus_oe_a[0]), .le_lo(le_lo_a[0]), .le_hi(le_hi_a[0]),
        .bus_dir(bus_dir_a[0]), .OEb(oeb_a[0]), .WEb_lo(web_lo_a[0]), .WEb_hi(web_hi_a[0])
    );

    ext_bus_master #(.WAIT_CYCLES(2), .HI_CACHE(1'b1)) u_dut1 (
        .wb_clk_i(clk), .wb_rst_i(rst), .req_valid(req_valid_a[1]), .req_ready(req_ready_a[1]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid_a[1]), .resp_rdata(resp_rdata_a[1]), .bus_out(bus_out_a[1]),
        .bus_in(bus_in_a[1]), .bus_oe(bus_oe_a[1]), .le_lo(le_lo_a[1]), .le_hi(le_hi_a[1]),
        .bus_dir(bus_dir_a[1]), .OEb(oeb_a[1]), .WEb_lo(web_lo_a[1]), .WEb_hi(web_hi_a[1])
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Device memory (what the pads actually wrote) and reference memory
    logic [15:0] dev_mem [longint];
    logic [15:0] ref_mem [longint];
    logic        ref_hv [2];
    logic [15:0] ref_tag [2];

    function automatic longint mkey(input int inst, input logic [31:0] ext);
        return (longint'(inst) << 32) | longint'(ext);
    endfunction

    function automatic logic [15:0] init_val(input logic [31:0] ext);
        return (ext[15:0] * 16'h9E37) ^ 16'h5A5A;
    endfunction

    function automatic logic [15:0] dev_rd(input longint k);
        logic [31:0] e;
        e = k[31:0];
        if (dev_mem.exists(k)) return dev_mem[k];
        return init_val(e);
    endfunction

    function automatic logic [15:0] ref_rd(input longint k);
        logic [31:0] e;
        e = k[31:0];
        if (ref_mem.exists(k)) return ref_mem[k];
        return init_val(e);
    endfunction

    // External device and bus monitor state
    int          hi_cnt [2]  = '{0, 0};
    int          lo_cnt [2]  = '{0, 0};
    int          inv_bad [2] = '{0, 0};
    int          bad_oe [2]  = '{0, 0};
    int          bad_we [2]  = '{0, 0};
    int          oe_run [2]  = '{0, 0};
    int          we_run [2]  = '{0, 0};
    logic [15:0] hi_lat [2]  = '{16'h0, 16'h0};
    logic [15:0] lo_lat [2]  = '{16'h0, 16'h0};
    logic [15:0] wd_hold [2] = '{16'h0, 16'h0};
    logic        wl_hold [2] = '{1'b0, 1'b0};
    logic        wh_hold [2] = '{1'b0, 1'b0};
    logic        prev_lh [2] = '{1'b0, 1'b0};
    logic        prev_ll [2] = '{1'b0, 1'b0};

    // Remember whether reset was sampled at the last edge (strobes cut short by reset)
    always @(posedge clk) rst_q <= rst;

    // External device: latches, read data driver, write capture on WEb rise, invariants
    always @(negedge clk) begin
        int          w;
        int          busy;
        longint      k;
        logic [15:0] cur;
        for (int i = 0; i < 2; i++) begin
            w = (i == 0) ? 0 : 2;
            if (le_hi_a[i]) hi_lat[i] = bus_out_a[i];
            if (le_lo_a[i]) lo_lat[i] = bus_out_a[i];
            if (le_hi_a[i] && !prev_lh[i]) hi_cnt[i]++;
            if (le_lo_a[i] && !prev_ll[i]) lo_cnt[i]++;
            prev_lh[i] = le_hi_a[i];
            prev_ll[i] = le_lo_a[i];
            busy = int'(le_lo_a[i]) + int'(le_hi_a[i]) + int'(!oeb_a[i])
                 + int'(!(web_lo_a[i] && web_hi_a[i]));
            if (busy > 1) inv_bad[i]++;
            if (bus_oe_a[i] && bus_dir_a[i]) inv_bad[i]++;
            k = mkey(i, {hi_lat[i], lo_lat[i]});
            if (!oeb_a[i]) begin
                oe_run[i]++;
            end else begin
                if (oe_run[i] != 0 && !rst_q && oe_run[i] != w + 1) bad_oe[i]++;
                oe_run[i] = 0;
            end
            // Only the last OEb-low cycle carries valid data
            bus_in_a[i] = (!oeb_a[i] && oe_run[i] == w + 1) ? dev_rd(k) : ~dev_rd(k);
            if (!(web_lo_a[i] && web_hi_a[i])) begin
                we_run[i]++;
                wd_hold[i] = bus_out_a[i];
                wl_hold[i] = !web_lo_a[i];
                wh_hold[i] = !web_hi_a[i];
            end else begin
                if (we_run[i] != 0) begin
                    cur = dev_rd(k);
                    if (wl_hold[i]) cur[7:0]  = wd_hold[i][7:0];
                    if (wh_hold[i]) cur[15:8] = wd_hold[i][15:8];
                    dev_mem[k] = cur;
                    if (!rst_q && we_run[i] != w + 1) bad_we[i]++;
                end
                we_run[i] = 0;
            end
        end
    end

    task automatic check_reset(input int i, input string t);
        check_eq({t, "_ready"}, req_ready_a[i], 0);
        check_eq({t, "_resp_valid"}, resp_valid_a[i], 0);
        check_eq({t, "_rdata"}, resp_rdata_a[i], 0);
        check_eq({t, "_bus_out"}, bus_out_a[i], 0);
        check_eq({t, "_bus_oe"}, bus_oe_a[i], 0);
        check_eq({t, "_le_lo"}, le_lo_a[i], 0);
        check_eq({t, "_le_hi"}, le_hi_a[i], 0);
        check_eq({t, "_bus_dir"}, bus_dir_a[i], 0);
        check_eq({t, "_oeb"}, oeb_a[i], 1);
        check_eq({t, "_web_lo"}, web_lo_a[i], 1);
        check_eq({t, "_web_hi"}, web_hi_a[i], 1);
    endtask

    // One request, entered and left at a negedge; checks against the reference model
    task automatic do_req(input int inst, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wstrb, input string t);
        int          w, nh, exp_hi, exp_lat, n, h0, l0;
        logic        hit;
        logic [31:0] ext0, ext1, exp_rd;
        logic [15:0] up, v;
        w    = (inst == 0) ? 0 : 2;
        ext0 = {1'b0, addr[31:2], 1'b0};
        ext1 = ext0 | 32'd1;
        up   = ext0[31:16];
        nh   = we ? (int'(wstrb[1:0] != 2'b00) + int'(wstrb[3:2] != 2'b00)) : 2;
        hit  = ref_hv[inst] && (ref_tag[inst] == up);
        exp_hi  = (nh > 0 && !hit) ? 1 : 0;
        exp_lat = (nh == 0) ? 1 : (2 * exp_hi + nh * (w + 4) + 1);
        if (nh > 0) begin
            ref_hv[inst]  = 1'b1;
            ref_tag[inst] = up;
        end
        exp_rd = {ref_rd(mkey(inst, ext1)), ref_rd(mkey(inst, ext0))};
        h0 = hi_cnt[inst];
        l0 = lo_cnt[inst];
        req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = wstrb;
        req_valid_a[inst] = 1'b1;
        n = 0;
        while (!req_ready_a[inst] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq({t, "_accept_timeout"}, 32'(n >= 50), 0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            req_valid_a[inst] = 1'b0;
        end while (!resp_valid_a[inst] && n < 200);
        check_eq({t, "_latency"}, n, exp_lat);
        check_eq({t, "_ready_at_resp"}, req_ready_a[inst], 1);
        check_eq({t, "_le_hi_pulses"}, hi_cnt[inst] - h0, exp_hi);
        check_eq({t, "_le_lo_pulses"}, lo_cnt[inst] - l0, nh);
        if (!we) begin
            check_eq({t, "_rdata"}, resp_rdata_a[inst], exp_rd);
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    v = ref_rd(mkey(inst, (b < 2) ? ext0 : ext1));
                    if (b % 2 == 0) v[7:0] = wdata[8*b +: 8];
                    else            v[15:8] = wdata[8*b +: 8];
                    ref_mem[mkey(inst, (b < 2) ? ext0 : ext1)] = v;
                end
            end
            check_eq({t, "_mem_hw0"}, dev_rd(mkey(inst, ext0)), ref_rd(mkey(inst, ext0)));
            check_eq({t, "_mem_hw1"}, dev_rd(mkey(inst, ext1)), ref_rd(mkey(inst, ext1)));
        end
    endtask

    initial begin
        logic [31:0] bases [3];
        int          n;
        int          n_resp;
        bases = '{32'h0000_1000, 32'h0040_0000, 32'h0123_4000};
        rst = 1'b1;
        req_valid_a[0] = 1'b0;
        req_valid_a[1] = 1'b0;
        req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_wstrb = 4'd0;
        bus_in_a[0] = 16'd0;
        bus_in_a[1] = 16'd0;
        ref_hv = '{1'b0, 1'b0};
        ref_tag = '{16'h0, 16'h0};
        for (int i = 0; i < 2; i++) begin
            dev_mem[mkey(i, 32'h0000_0800)] = 16'h1111;
            dev_mem[mkey(i, 32'h0000_0801)] = 16'h2222;
            ref_mem[mkey(i, 32'h0000_0800)] = 16'h1111;
            ref_mem[mkey(i, 32'h0000_0801)] = 16'h2222;
        end
        repeat (3) @(negedge clk);
        check_reset(0, "rst0");
        check_reset(1, "rst1");
        rst = 1'b0;
        @(negedge clk);

        // Cold read: upper phase, both halfwords
        do_req(0, 1'b0, 32'h0000_1000, 32'd0, 4'h0, "t1_rd");
        check_eq("t1_rdata_const", resp_rdata_a[0], 32'h2222_1111);
        check_eq("t1_hi_addr", hi_lat[0], 16'h0000);
        check_eq("t1_lo_addr", lo_lat[0], 16'h0801);
        // Full write with new upper bits
        do_req(0, 1'b1, 32'h0040_0018, 32'hDEAD_BEEF, 4'hF, "t2_wr");
        check_eq("t2_hi_addr", hi_lat[0], 16'h0020);
        check_eq("t2_mem_lo_const", dev_rd(mkey(0, 32'h0020_000C)), 16'hBEEF);
        // Single-byte write in halfword 1, cache hit
        do_req(0, 1'b1, 32'h0040_0018, 32'h1234_5678, 4'b1000, "t3_wr");
        check_eq("t3_mem_const", dev_rd(mkey(0, 32'h0020_000D)), 16'h12AD);
        // Back-to-back reads, second hits the cache
        do_req(0, 1'b0, 32'h0000_1000, 32'd0, 4'h0, "t4_rd_a");
        do_req(0, 1'b0, 32'h0000_1004, 32'd0, 4'h0, "t4_rd_b");
        // Wait states on the second instance
        do_req(1, 1'b0, 32'h0000_1000, 32'd0, 4'h0, "t5_rd");
        check_eq("t5_rdata_const", resp_rdata_a[1], 32'h2222_1111);
        // Write without strobes: no bus activity
        do_req(0, 1'b1, 32'h0000_2000, 32'hCAFE_F00D, 4'h0, "wr_nostrb");

        // Randomized traffic over a few upper-address regions
        repeat (60) begin
            do_req(0, 1'($urandom_range(0, 1)), bases[$urandom_range(0, 2)] + 32'($urandom_range(0, 7) * 4),
                   $urandom, 4'($urandom_range(0, 15)), "rnd0");
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        repeat (15) begin
            do_req(1, 1'($urandom_range(0, 1)), bases[$urandom_range(0, 2)] + 32'($urandom_range(0, 7) * 4),
                   $urandom, 4'($urandom_range(0, 15)), "rnd1");
        end

        // Reset in the middle of a read
        req_we = 1'b0; req_addr = 32'h0000_1000; req_wstrb = 4'h0;
        req_valid_a[0] = 1'b1;
        n = 0;
        while (!req_ready_a[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        req_valid_a[0] = 1'b0;
        n = 0;
        while (oeb_a[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("t6_reach_rd_timeout", 32'(n >= 50), 0);
        rst = 1'b1;
        @(negedge clk);
        check_reset(0, "t6_rst");
        rst = 1'b0;
        ref_hv = '{1'b0, 1'b0};
        n_resp = 0;
        repeat (20) begin
            @(negedge clk);
            if (resp_valid_a[0]) n_resp++;
        end
        check_eq("t6_no_resp", n_resp, 0);
        do_req(0, 1'b0, 32'h0000_1000, 32'd0, 4'h0, "t6_rd");

        for (int i = 0; i < 2; i++) begin
            check_eq($sformatf("invariants%0d", i), inv_bad[i], 0);
            check_eq($sformatf("oeb_width%0d", i), bad_oe[i], 0);
            check_eq($sformatf("web_width%0d", i), bad_we[i], 0);
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
